// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB3 slave UART with TX and RX byte FIFOs, a runtime baud
// divisor, sticky status flags and built-in 8N1 transmitter/receiver.
// Optional interrupt logic is compiled in when UART_IRQ_EN is defined.
//
// Bus handshake: an access fires on the clock edge where S_PSELx and
// S_PENABLE are both high; S_PREADY is always 1, so every access completes
// in that single cycle and takes effect exactly once. S_PRDATA and
// S_PSLVERR are combinational during the access phase.
module apb_uart_fifo #(
    parameter int BUS_WIDTH = 16,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int DIV_RESET = 434,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    output logic                 S_PSLVERR,
    output logic                 tx_wire,
    input  logic                 rx_wire,
    output logic                 irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    // Bus decode
    logic w_access, w_wr, w_rd;
    logic w_data_wr, w_data_rd, w_status_rd, w_div_wr;
    assign w_access    = S_PSELx & S_PENABLE;
    assign w_wr        = w_access & S_PWRITE;
    assign w_rd        = w_access & ~S_PWRITE;
    assign w_data_wr   = w_wr & (S_PADDR == ADDR_DATA);
    assign w_data_rd   = w_rd & (S_PADDR == ADDR_DATA);
    assign w_status_rd = w_rd & (S_PADDR == ADDR_STATUS);
    assign w_div_wr    = w_wr & (S_PADDR == ADDR_DIV);

    // Registers
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_wdiv;
    logic                 r_rx_ovf, r_tx_ovf, r_frame_err;
    assign w_wdiv = S_PWDATA[DIV_WIDTH-1:0];

    // TX FIFO
    logic [7:0]     r_tx_mem [TX_DEPTH];
    logic [TX_AW:0] r_tx_wp, r_tx_rp;
    logic           w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_drop;
    logic [7:0]     w_tx_head;

    // RX FIFO
    logic [7:0]     r_rx_mem [RX_DEPTH];
    logic [RX_AW:0] r_rx_wp, r_rx_rp;
    logic           w_rx_empty, w_rx_full, w_rx_push, w_rx_push_ok, w_rx_pop, w_rx_ovf_evt;
    logic [7:0]     w_rx_head;

    // TX engine
    logic [1:0]           r_tx_state;
    logic [DIV_WIDTH-1:0] r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [7:0]           r_tx_shift;
    logic                 r_tx;

    // RX engine
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic [2:0]           r_rx_state;
    logic [DIV_WIDTH-1:0] r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [7:0]           r_rx_shift;
    logic                 w_ferr_evt;

    // TX FIFO flags; a pop frees a slot, so a push to a full FIFO still lands
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                        (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rp[TX_AW-1:0]];
    assign w_tx_pop   = ~w_tx_empty & ((r_tx_state == TX_IDLE) |
                        ((r_tx_state == TX_STOP) && (r_tx_cnt == '0)));
    assign w_tx_push  = w_data_wr & (~w_tx_full | w_tx_pop);
    assign w_tx_drop  = w_data_wr & ~w_tx_push;

    // RX FIFO flags; a pop on empty is rejected
    assign w_rx_empty   = (r_rx_wp == r_rx_rp);
    assign w_rx_full    = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                          (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
    assign w_rx_head    = r_rx_mem[r_rx_rp[RX_AW-1:0]];
    assign w_rx_pop     = w_data_rd & ~w_rx_empty;
    assign w_rx_push    = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && r_rx_s2;
    assign w_ferr_evt   = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && !r_rx_s2;
    assign w_rx_push_ok = w_rx_push & (~w_rx_full | w_rx_pop);
    assign w_rx_ovf_evt = w_rx_push & ~w_rx_push_ok;

    // FIFO storage writes (no reset needed; pointers gate validity)
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= S_PWDATA[7:0];
        if (w_rx_push_ok) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= r_rx_shift;
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push)    r_tx_wp <= r_tx_wp + (TX_AW+1)'(1);
            if (w_tx_pop)     r_tx_rp <= r_tx_rp + (TX_AW+1)'(1);
            if (w_rx_push_ok) r_rx_wp <= r_rx_wp + (RX_AW+1)'(1);
            if (w_rx_pop)     r_rx_rp <= r_rx_rp + (RX_AW+1)'(1);
        end
    end

    // Divisor and sticky flags; a new event on a STATUS-read edge wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= DIV_WIDTH'(DIV_RESET);
            r_rx_ovf    <= 1'b0;
            r_tx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_div_wr) r_div <= (w_wdiv < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : w_wdiv;
            if (w_status_rd) begin
                r_rx_ovf    <= 1'b0;
                r_tx_ovf    <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_rx_ovf_evt) r_rx_ovf    <= 1'b1;
            if (w_tx_drop)    r_tx_ovf    <= 1'b1;
            if (w_ferr_evt)   r_frame_err <= 1'b1;
        end
    end

    // TX FSM: bit length latched from r_div at each bit start, so DIV writes apply at boundaries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= r_div - DIV_WIDTH'(1);
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= 3'd0;
                        r_tx_cnt   <= r_div - DIV_WIDTH'(1);
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - DIV_WIDTH'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_cnt <= r_div - DIV_WIDTH'(1);
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - DIV_WIDTH'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == '0) begin
                        if (w_tx_pop) begin
                            r_tx_shift <= w_tx_head;
                            r_tx       <= 1'b0;
                            r_tx_cnt   <= r_div - DIV_WIDTH'(1);
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - DIV_WIDTH'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX synchroniser plus previous-sample register for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_wire;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX FSM: start bit checked at DIV/2, later samples every DIV cycles (mid-bit)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_cnt   <= (r_div >> 1) - DIV_WIDTH'(1);
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == '0) begin
                        if (r_rx_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_bit   <= 3'd0;
                            r_rx_cnt   <= r_div - DIV_WIDTH'(1);
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - DIV_WIDTH'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_cnt   <= r_div - DIV_WIDTH'(1);
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - DIV_WIDTH'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == '0) r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
                    else                r_rx_cnt   <= r_rx_cnt - DIV_WIDTH'(1);
                end
                RX_WAIT: begin
                    if (r_rx_s2) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [7:0] w_status;
    logic       w_tx_busy;
    logic [2:0] w_ctrl;
    assign w_tx_busy = (r_tx_state != TX_IDLE) | ~w_tx_empty;
    assign w_status  = {r_frame_err, r_tx_ovf, r_rx_ovf, w_tx_busy,
                        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

`ifdef UART_IRQ_EN
    logic [2:0] r_ctrl;
    logic       r_irq;
    logic       w_ctrl_wr;
    assign w_ctrl_wr = w_wr & (S_PADDR == ADDR_CTRL);

    // CTRL enables and registered interrupt (rx_not_empty, tx_empty, sticky errors)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= S_PWDATA[2:0];
            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty) |
                     (r_ctrl[2] & (r_rx_ovf | r_tx_ovf | r_frame_err));
        end
    end
    assign w_ctrl = r_ctrl;
    assign irq    = r_irq;
`else
    assign w_ctrl = 3'b000;
    assign irq    = 1'b0;
`endif

    // Read mux: zero unless a read is selected; DATA shows the RX head before the pop
    always_comb begin
        S_PRDATA = '0;
        if (S_PSELx && !S_PWRITE) begin
            case (S_PADDR)
                ADDR_DATA:   if (!w_rx_empty) S_PRDATA[7:0] = w_rx_head;
                ADDR_STATUS: S_PRDATA[7:0] = w_status;
                ADDR_DIV:    S_PRDATA[DIV_WIDTH-1:0] = r_div;
                ADDR_CTRL:   S_PRDATA[2:0] = w_ctrl;
                default:     S_PRDATA = '0;
            endcase
        end
    end

    assign S_PREADY  = 1'b1;
    assign S_PSLVERR = w_tx_drop | (w_data_rd & w_rx_empty);
    assign tx_wire   = r_tx;

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Testbench for apb_uart_fifo: directed sequence with randomized bytes and
// divisors, checked against a queue-based model of the FIFOs and flags.
module tb_apb_uart_fifo;
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  S_PADDR = '0;
    logic        S_PWRITE = 1'b0;
    logic        S_PSELx = 1'b0;
    logic        S_PENABLE = 1'b0;
    logic [15:0] S_PWDATA = '0;
    logic [15:0] S_PRDATA;
    logic        S_PREADY;
    logic        S_PSLVERR;
    logic        tx_wire;
    logic        rx_wire = 1'b1;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] m_rx_q[$];
    logic [7:0] tx_exp_q[$];
    bit         m_rx_ovf, m_tx_ovf, m_ferr;
    int         m_div;

    apb_uart_fifo dut (
        .clk(clk), .reset_n(reset_n), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
        .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
        .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
        .tx_wire(tx_wire), .rx_wire(rx_wire), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All APB tasks start and end on a falling clock edge
    task automatic apb_write(input logic [1:0] addr, input logic [15:0] data, output logic err);
        S_PADDR = addr; S_PWRITE = 1'b1; S_PWDATA = data; S_PSELx = 1'b1; S_PENABLE = 1'b0;
        @(negedge clk);
        S_PENABLE = 1'b1;
        #1;
        err = S_PSLVERR;
        @(posedge clk);
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] addr, output logic [15:0] data, output logic err);
        S_PADDR = addr; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0;
        @(negedge clk);
        S_PENABLE = 1'b1;
        #1;
        data = S_PRDATA;
        err  = S_PSLVERR;
        @(posedge clk);
        @(negedge clk);
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
    endtask

    task automatic set_div(input int d);
        logic e;
        apb_write(A_DIV, 16'(d), e);
        m_div = d;
    endtask

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s    = '0;
        s[1] = 1'b1;
        s[2] = (m_rx_q.size() == 8);
        s[3] = (m_rx_q.size() == 0);
        s[5] = m_rx_ovf;
        s[6] = m_tx_ovf;
        s[7] = m_ferr;
        return s;
    endfunction

    task automatic status_check(input string tag);
        logic [15:0] d;
        logic        e;
        apb_read(A_STATUS, d, e);
        check(tag, d, exp_status());
        m_rx_ovf = 0; m_tx_ovf = 0; m_ferr = 0;
    endtask

    // Follows tx_wire from the next start bit; each bit must hold for exactly div cycles
    task automatic tx_monitor(input int nframes, input int div);
        int          waited;
        int          bad;
        logic [7:0]  b;
        logic [9:0]  frame;
        waited = 0;
        while (tx_wire !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tx_start_seen", tx_wire, 1'b0);
        for (int f = 0; f < nframes; f++) begin
            b = tx_exp_q.pop_front();
            frame = {1'b1, b, 1'b0};
            for (int k = 0; k < 10; k++) begin
                bad = 0;
                for (int c = 0; c < div; c++) begin
                    if (tx_wire !== frame[k]) bad++;
                    @(negedge clk);
                end
                check($sformatf("tx_f%0d_bit%0d", f, k), bad, 0);
            end
        end
    endtask

    // Drives one 8N1 frame at the model divisor and updates the model
    task automatic rx_send(input logic [7:0] b, input bit stop_bit);
        rx_wire = 1'b0;
        repeat (m_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_wire = b[i];
            repeat (m_div) @(negedge clk);
        end
        rx_wire = stop_bit;
        repeat (m_div) @(negedge clk);
        rx_wire = 1'b1;
        if (!stop_bit) repeat (4) @(negedge clk);
        if (!stop_bit)               m_ferr = 1;
        else if (m_rx_q.size() < 8)  m_rx_q.push_back(b);
        else                         m_rx_ovf = 1;
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        logic [7:0]  rb;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_tx_wire", tx_wire, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_prdata", S_PRDATA, 16'h0);
        check("rst_pslverr", S_PSLVERR, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("pready", S_PREADY, 1'b1);

        status_check("status_after_reset");
        apb_read(A_DIV, d, e);
        check("div_reset", d, 16'd434);
        apb_read(A_CTRL, d, e);
        check("ctrl_reset", d, 16'h0);
        apb_write(A_CTRL, 16'h0007, e);
        apb_read(A_CTRL, d, e);
`ifdef UART_IRQ_EN
        check("ctrl_rw", d, 16'h0007);
        apb_write(A_CTRL, 16'h0000, e);
`else
        check("ctrl_ignored", d, 16'h0);
        check("irq_tied", irq, 1'b0);
`endif

        // Divisor floor
        apb_write(A_DIV, 16'd0, e);
        apb_read(A_DIV, d, e);
        check("div_zero_to_2", d, 16'd2);
        apb_write(A_DIV, 16'd1, e);
        apb_read(A_DIV, d, e);
        check("div_one_to_2", d, 16'd2);

        // STATUS writes are ignored
        apb_write(A_STATUS, 16'hFFFF, e);
        check("status_wr_err", e, 1'b0);
        status_check("status_after_wr");

        // Single frame 0x55 at DIV=4, with start-bit latency
        set_div(4);
        tx_exp_q.push_back(8'h55);
        apb_write(A_DATA, 16'h0055, e);
        check("tx_wr_ok", e, 1'b0);
        lat = 0;
        while (tx_wire !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("tx_latency_1_2", (lat >= 1 && lat <= 2), 1);
        tx_monitor(1, 4);
        repeat (3) @(negedge clk);

        // 10 back-to-back writes: byte 1 moves straight into the shifter,
        // bytes 2..9 fill the FIFO, byte 10 overflows
        for (int i = 1; i <= 9; i++) tx_exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    apb_write(A_DATA, 16'(i), e);
                    check($sformatf("tx_burst_err%0d", i), e, (i == 10));
                    if (i == 10) m_tx_ovf = 1;
                end
            end
            tx_monitor(9, 4);
        join
        repeat (3) @(negedge clk);
        status_check("status_tx_ovf");
        status_check("status_tx_ovf_clr");

        // Random bytes at a random small divisor
        set_div($urandom_range(2, 5));
        for (int i = 0; i < 2; i++) tx_exp_q.push_back(8'($urandom_range(0, 255)));
        fork
            begin
                apb_write(A_DATA, {8'h00, tx_exp_q[0]}, e);
                apb_write(A_DATA, {8'h00, tx_exp_q[1]}, e);
            end
            tx_monitor(2, m_div);
        join
        repeat (3) @(negedge clk);

        // RX single byte 0xA3 at DIV=8
        set_div(8);
        repeat (2) @(negedge clk);
        rx_send(8'hA3, 1'b1);
        status_check("status_rx_one");
        apb_read(A_DATA, d, e);
        check("rx_data_a3", d, {8'h00, m_rx_q.pop_front()});
        check("rx_data_err", e, 1'b0);
        status_check("status_rx_drained");

        // 9 frames without reading: 9th overflows, first 8 kept
        for (int i = 0; i < 9; i++) begin
            rb = 8'($urandom_range(0, 255));
            rx_send(rb, 1'b1);
        end
        status_check("status_rx_full_ovf");
        status_check("status_rx_ovf_clr");
        for (int i = 0; i < 8; i++) begin
            apb_read(A_DATA, d, e);
            check($sformatf("rx_read%0d", i), d, {8'h00, m_rx_q.pop_front()});
        end
        apb_read(A_DATA, d, e);
        check("rx_empty_data", d, 16'h0);
        check("rx_empty_err", e, 1'b1);

        // Framing error: nothing pushed
        rx_send(8'($urandom_range(0, 255)), 1'b0);
        status_check("status_frame_err");

        // Reset mid-frame with bytes still queued
        set_div(4);
        apb_write(A_DATA, 16'h0000, e);
        apb_write(A_DATA, 16'h0000, e);
        apb_write(A_DATA, 16'h0000, e);
        repeat (2) @(negedge clk);
        check("tx_mid_frame_low", tx_wire, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("tx_high_on_reset", tx_wire, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m_rx_q.delete();
        m_rx_ovf = 0; m_tx_ovf = 0; m_ferr = 0;
        status_check("status_after_mid_reset");
        apb_read(A_DIV, d, e);
        check("div_after_mid_reset", d, 16'd434);
        check("tx_idle_after_reset", tx_wire, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
